// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Characterizes a 3-input / 1-output combinational circuit. It walks the
//   eight input rows 000..111 on {in1,in2,in3} and holds each row for SETTLE
//   cycles. At the end of each row it samples dut_out into table_out[7-row],
//   so row 000 lands in the MSB. When the last row has been sampled, it
//   compares the assembled code with the expected code that was latched at
//   start.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    sweep request (taken in IDLE only), cancel (taken in SETTLE only)
//   expected[7:0]   expected truth-table code, latched when start is accepted
//   in1..in3        row drive to the CUT; in1 is the row MSB
//   dut_out         CUT output
//   busy, done      sweep in progress; one-cycle completion pulse
//   table_out[7:0]  captured code, held until the next accepted start
//   match           table_out == latched expected code, valid from done on
//
// Optional feature (macro TT_SWEEP_SYNC_EN)
//   When defined, dut_out passes through a two-flop synchronizer before it is
//   sampled. The sampled value then lags the CUT by two cycles, which is why
//   SETTLE must be at least 3.
module truth_table_sweeper #(
    parameter int SETTLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       table_q, table_d;
    logic [7:0]       exp_q, exp_d;
    logic             match_q, match_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       drv_q, drv_d;
    logic             sample_bit;
    logic             last_sample;

    if (SETTLE < 1 || SETTLE > 255) begin : g_settle_range
        $error("truth_table_sweeper: SETTLE must be in 1..255");
    end
    if ((2 ** CNT_W) <= SETTLE) begin : g_cnt_w
        $error("truth_table_sweeper: CNT_W too narrow for SETTLE");
    end

`ifdef TT_SWEEP_SYNC_EN
    logic sync1_q, sync2_q;

    if (SETTLE < 3) begin : g_sync_settle
        $error("truth_table_sweeper: SETTLE must be >= 3 with the input synchronizer");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= dut_out;
            sync2_q <= sync1_q;
        end
    end
    assign sample_bit = sync2_q;
`else
    assign sample_bit = dut_out;
`endif

    assign last_sample = (cnt_q == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort wins over start and over the last sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && !abort) state_d = S_SETTLE;
            S_SETTLE: begin
                if (abort)                          state_d = S_IDLE;
                else if (last_sample && row_q == 3'd7) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath / output next values. Every output is a flop, so each
    // output's next value is derived from state_d.
    always_comb begin
        row_d   = row_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        exp_d   = exp_q;
        match_d = match_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    exp_d   = expected;
                    table_d = 8'h00;
                    match_d = 1'b0;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    row_d   = 3'd0;
                    cnt_d   = '0;
                    match_d = 1'b0;
                end else if (last_sample) begin
                    table_d[3'd7 - row_q] = sample_bit;
                    cnt_d = '0;
                    if (row_q == 3'd7) begin
                        row_d   = 3'd0;
                        // table_d already holds the final bit here
                        match_d = (table_d == exp_q);
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_SETTLE);
        done_d = (state_d == S_DONE);
        drv_d  = (state_d == S_SETTLE) ? row_d : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= 3'd0;
            cnt_q   <= '0;
            table_q <= 8'h00;
            exp_q   <= 8'h00;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drv_q   <= 3'd0;
        end else begin
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drv_q   <= drv_d;
        end
    end

    assign {in1, in2, in3} = drv_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=4 and SETTLE=1), each
// driving a modelled CUT whose output is a truth-table lookup, optionally
// delayed by two cycles.
module tb_truth_table_sweeper;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, abort0, start1, abort1;
    logic [7:0] exp0, exp1;
    logic       a0, b0, c0, a1, b1, c1;
    logic       dout0, dout1;
    logic       busy0, done0, match0, busy1, done1, match1;
    logic [7:0] tab0, tab1;

    logic [7:0] fn0, fn1;
    bit         dly0;
    logic       p0_d1 = 1'b0, p0_d2 = 1'b0, p1_d1 = 1'b0, p1_d2 = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    truth_table_sweeper #(.SETTLE(S0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .expected(exp0), .in1(a0), .in2(b0), .in3(c0), .dut_out(dout0),
        .busy(busy0), .done(done0), .table_out(tab0), .match(match0)
    );

    truth_table_sweeper #(.SETTLE(S1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .expected(exp1), .in1(a1), .in2(b1), .in3(c1), .dut_out(dout1),
        .busy(busy1), .done(done1), .table_out(tab1), .match(match1)
    );

    // Truth-table lookup: row 000 is the code's MSB
    function automatic logic tt(input logic [7:0] f, input logic [2:0] r);
        return f[3'd7 - r];
    endfunction

    always @(posedge clk) begin
        p0_d1 <= tt(fn0, {a0, b0, c0});
        p0_d2 <= p0_d1;
        p1_d1 <= tt(fn1, {a1, b1, c1});
        p1_d2 <= p1_d1;
    end
    assign dout0 = dly0 ? p0_d2 : tt(fn0, {a0, b0, c0});
    assign dout1 = p1_d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full sweep on instance 0. Called at a negedge while idle and returns at
    // the negedge after the done cycle.
    task automatic sweep0(input logic [7:0] fn, input logic [7:0] ex, input bit dly, input string tag);
        int  cyc;
        bit  got, rows_ok;
        fn0 = fn; dly0 = dly; exp0 = ex; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        exp0 = 8'($urandom);  // the latched copy must be what gets compared
        cyc = 1; got = 0; rows_ok = 1;
        while (cyc <= 8 * S0 + 6) begin
            if (done0) begin got = 1; break; end
            if (cyc <= 8 * S0 && ({a0, b0, c0} != 3'((cyc - 1) / S0) || !busy0)) rows_ok = 0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done latency"}, got ? cyc : 0, 8 * S0 + 1);
        chk({tag, " row drive/busy"}, rows_ok, 1);
        chk({tag, " busy in done"}, busy0, 0);
        chk({tag, " table"}, tab0, fn);
        chk({tag, " match"}, match0, (fn == ex));
        @(negedge clk);
        chk({tag, " done one cycle"}, done0, 0);
    endtask

    initial begin
        int        cyc, dcnt, first_done;
        bit        got, b34, b35, no_done;
        logic [7:0] ref1, rf, re;

        rst_n = 1'b0;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
        exp0 = 8'h00; exp1 = 8'h00; fn0 = 8'hCE; fn1 = 8'hCE; dly0 = 0;
        repeat (3) @(negedge clk);
        chk("reset drive", {a0, b0, c0}, 3'b000);
        chk("reset busy/done", {busy0, done0, busy1, done1}, 4'b0000);
        chk("reset table", tab0, 8'h00);
        chk("reset match", match0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep0(8'hCE, 8'hCE, 0, "ce");
        sweep0(8'hCE, 8'hCF, 0, "cf");
        sweep0(8'hCE, 8'hCE, 0, "ce again");

        // SETTLE=1 with a 2-cycle CUT: row r sees the CUT's response to row
        // r-2; rows 0 and 1 see the idle drive 000.
        ref1 = 8'h00;
        for (int r = 0; r < 8; r++) ref1[7 - r] = tt(8'hCE, 3'((r < 2) ? 0 : r - 2));
        exp1 = 8'hCE; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1; got = 0;
        while (cyc <= 20) begin
            if (done1) begin got = 1; break; end
            @(negedge clk);
            cyc++;
        end
        chk("s1 done latency", got ? cyc : 0, 9);
        chk("s1 wrong table", tab1, ref1);
        chk("s1 match", match1, 0);
        @(negedge clk);
        sweep0(8'hCE, 8'hCE, 1, "delayed s4");

        // Abort while row 3 is driven
        fn0 = 8'hCE; dly0 = 0; exp0 = 8'hCE; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while ({a0, b0, c0} != 3'd3 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("abort reach row3", {a0, b0, c0}, 3'd3);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort busy", busy0, 0);
        chk("abort drive", {a0, b0, c0}, 3'b000);
        chk("abort partial table", tab0, 8'hC0);
        chk("abort match", match0, 0);
        no_done = 1;
        repeat (40) begin
            if (done0 || busy0) no_done = 0;
            @(negedge clk);
        end
        chk("abort no done", no_done, 1);

        // abort beats start in the same cycle
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort0 = 1'b0;
        chk("abort over start", busy0, 0);
        @(negedge clk);

        // Reset mid-row 5
        fn0 = 8'hCE; exp0 = 8'hCE; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while ({a0, b0, c0} != 3'd5 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("rst reach row5", {a0, b0, c0}, 3'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async drive", {a0, b0, c0}, 3'b000);
        chk("rst async busy/done", {busy0, done0}, 2'b00);
        chk("rst async table", tab0, 8'h00);
        chk("rst async match", match0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep0(8'hCE, 8'hCE, 0, "post rst");

        // start held high for 40 cycles
        fn0 = 8'hCE; exp0 = 8'hCE; start0 = 1'b1;
        dcnt = 0; first_done = 0; b34 = 0; b35 = 0;
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            if (done0) begin dcnt++; if (first_done == 0) first_done = k; end
            if (k == 34) b34 = busy0;
            if (k == 35) b35 = busy0;
        end
        start0 = 1'b0;
        chk("held start done count", dcnt, 1);
        chk("held start done pos", first_done, 33);
        chk("held start idle gap", b34, 0);
        chk("held start restart", b35, 1);
        cyc = 0;
        while (!done0 && cyc < 80) begin @(negedge clk); cyc++; end
        chk("held start second done", done0, 1);
        chk("held start second table", tab0, 8'hCE);
        @(negedge clk);

        // Random functions and expected codes
        for (int i = 0; i < 12; i++) begin
            rf = 8'($urandom);
            re = ($urandom_range(1, 0) == 1) ? rf : 8'($urandom);
            sweep0(rf, re, bit'($urandom_range(1, 0)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential characterizer for 3-input, 1-output logic gates and circuits.
- Steps through all 8 input combinations and drives them into the circuit under test (CUT). Waits a settle interval per combination, then samples the CUT output.
- Assembles the 8-bit truth-table hex code (e.g. 0xCE) and compares it against an expected code.
- Sits beside each combinational circuit block on the test harness: the block reads back a truth table, where the circuit blocks implement one.

Parameters:
- SETTLE, default 4: clock cycles each input combination is held before sampling. Legal range is 1..255 without the optional feature and 3..255 with it.
- CNT_W, default 8: width of the settle counter. Must satisfy 2**CNT_W > SETTLE.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request. Sampled only in IDLE.
- abort  input  1  cancels a sweep in progress.
- expected  input  8  expected truth-table code. Latched when start is accepted.
- in1  output  1  drive to CUT, row-index MSB.
- in2  output  1  drive to CUT, row-index middle bit.
- in3  output  1  drive to CUT, row-index LSB.
- dut_out  input  1  CUT output.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  captured truth-table code. Held until the next accepted start.
- match  output  1  table_out == expected code. Valid from done onward; held.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; row and cnt clear to 0.
  - {in1,in2,in3}=000, busy=0, done=0, table_out=8'h00, match=0, latched expected=0.
- Row encoding: row = {in1,in2,in3}. The output for row r is stored at table_out bit (7-r), so row 000 is the MSB. A CUT computing 0xCE (rows 000..111 giving 1,1,0,0,1,1,1,0) yields table_out=8'hCE.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - Drives 000.
  - On start=1 (with abort=0): latch expected, clear table_out and match, set row=0 and cnt=0, go to SETTLE.
  - busy goes high on the same edge.
- SETTLE:
  - {in1,in2,in3}=row, driven from registers.
  - Each cycle cnt increments.
  - At the edge where cnt==SETTLE-1, the sampled value is written into table_out[7-row] and cnt clears.
  - If row==7 at that edge, go to DONE. Otherwise row increments.
- DONE:
  - Lasts one cycle. done=1, busy=0; drives return to 000.
  - match is registered on entry as (captured table == latched expected).
  - Go to IDLE next edge.
- Timing:
  - With start accepted at edge E0, done is high during the cycle following edge E0+8*SETTLE.
  - Total sweep is 8*SETTLE cycles.
  - Each row is driven for exactly SETTLE cycles.
- start while busy or in DONE: ignored, no restart.
- abort=1 in SETTLE:
  - Next edge goes to IDLE, busy=0, done not pulsed, drives 000.
  - table_out keeps its partial capture; match=0.
- abort in IDLE or DONE: no effect. abort has priority over start in the same cycle.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- SETTLE=1: each row is held 1 cycle and sampled on the edge ending that cycle; total 8 cycles.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: TT_SWEEP_SYNC_EN.
- Defined:
  - dut_out passes through a two-flop synchronizer (reset to 0) before sampling.
  - The sample instant is unchanged (cnt==SETTLE-1). The sampled value therefore reflects the CUT output 2 cycles earlier, which is why SETTLE>=3 is required.
  - An initial-block or elaboration check flags SETTLE<3.
- Undefined: dut_out is sampled directly; SETTLE>=1.

Test Plan:
- SETTLE=4, bench models the 0xCE function on in1..in3, expected=8'hCE, start pulse:
  - Row drives 000..111 for 4 cycles each.
  - done one cycle at start+32.
  - table_out=8'hCE, match=1.
- Same CUT model, expected=8'hCF: table_out=8'hCE, match=0. A second start with expected=8'hCE gives match=1.
- Bench models a CUT with a 2-cycle output delay, SETTLE=1 (macro off):
  - Wrong table captured, match=0.
  - Repeat with SETTLE=4: table_out=8'hCE.
- abort asserted while row=3:
  - Next edge busy=0, drives 000, no done.
  - table_out bits [7:5] hold captured values (1,1,0 for the 0xCE model); match=0.
- rst_n pulled low mid-row 5: all outputs return to reset values asynchronously. A start after release sweeps cleanly to 8'hCE.
- start held high for 40 cycles: exactly one sweep, one done pulse; a new sweep begins the cycle after DONE returns to IDLE.
